// File: rtl/gate_test_sequencer.sv
// Stimulus/compare sequencer for a 2-input gate under test: sweeps {a,b}
// through 00..11, holds each for dwell cycles, checks y against a truth table.
`timescale 1ns/1ps
module gate_test_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned ERR_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         truth,
  input  logic               y,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [3:0]         fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         truth_q, truth_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [3:0]         fail_q, fail_d;
  logic               pass_q, pass_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_eff;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    truth_d = truth_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dwell_d = dwell_eff;
          truth_d = truth;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = dwell_eff - DWELL_W'(1);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // abort takes priority over the final compare: no result update at all
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          if (y != truth_q[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
          end
          if (idx_q == 2'd3) begin
            state_d = FIN;
            pass_d  = (fail_d == '0);
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = dwell_q - DWELL_W'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state so {a,b}/busy/done never glitch.
    busy_d = (state_d == DRIVE);
    done_d = (state_d == FIN);
    ab_d   = busy_d ? idx_d : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      truth_q <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      truth_q <= truth_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: sweep-level reference model plus directed
// scenarios and randomized start/abort/dwell/truth traffic.
`timescale 1ns/1ps
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort;
  logic [7:0] dwell;
  logic [3:0] truth;
  int         gm;

  logic       a0, b0, busy0, done0, pass0, y0;
  logic [2:0] err0;
  logic [3:0] fail0;
  logic       a1, b1, busy1, done1, pass1, y1;
  logic [0:0] err1;
  logic [3:0] fail1;

  int checks = 0;
  int failures = 0;

  function automatic logic gut(input int m, input logic [1:0] v);
    case (m)
      0:       return v != 2'd0;
      1:       return v == 2'd3;
      2:       return 1'b0;
      default: return v[1] ^ v[0];
    endcase
  endfunction

  always_comb y0 = gut(gm, {a0, b0});
  always_comb y1 = gut(gm, {a1, b1});

  gate_test_sequencer #(.DWELL_W(8), .ERR_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dwell(dwell),
    .truth(truth), .y(y0), .a(a0), .b(b0), .busy(busy0), .done(done0),
    .pass(pass0), .err_cnt(err0), .fail_vec(fail0));

  gate_test_sequencer #(.DWELL_W(8), .ERR_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dwell(dwell),
    .truth(truth), .y(y1), .a(a1), .b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err1), .fail_vec(fail1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: a sweep is a run of 4*D cycles; cycle t drives vector t/D
  // and samples y when t%D == D-1.
  bit         m_run, m_fin;
  int         m_t, m_D, m_mis, m_v;
  logic [3:0] m_truth, m_fail;
  logic       m_pass, m_smp, m_bad;

  always_comb begin
    m_v   = m_t / m_D;
    m_smp = m_run && ((m_t % m_D) == m_D - 1);
    m_bad = m_smp && (gut(gm, m_v[1:0]) != m_truth[m_v[1:0]]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_fin <= 0; m_t <= 0; m_D <= 1; m_mis <= 0;
      m_truth <= '0; m_fail <= '0; m_pass <= 1'b0;
    end else if (m_fin) begin
      m_fin <= 0;
    end else if (m_run) begin
      if (abort) begin
        m_run <= 0; m_pass <= 1'b0;
      end else begin
        if (m_bad) begin
          m_fail[m_v[1:0]] <= 1'b1;
          m_mis <= m_mis + 1;
        end
        m_t <= m_t + 1;
        if (m_t + 1 == 4 * m_D) begin
          m_run <= 0; m_fin <= 1;
          m_pass <= ((m_fail | (m_bad ? (4'b0001 << m_v[1:0]) : 4'b0000)) == 4'b0000);
        end
      end
    end else if (start) begin
      m_run <= 1; m_t <= 0; m_D <= (dwell == 8'd0) ? 1 : int'(dwell);
      m_truth <= truth; m_mis <= 0; m_fail <= '0; m_pass <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] eab;
    eab = m_run ? m_v[1:0] : 2'd0;
    chk("ab0", {a0, b0}, eab);
    chk("ab1", {a1, b1}, eab);
    chk("busy0", busy0, m_run);
    chk("busy1", busy1, m_run);
    chk("done0", done0, m_fin);
    chk("done1", done1, m_fin);
    chk("pass0", pass0, m_pass);
    chk("pass1", pass1, m_pass);
    chk("fail0", fail0, m_fail);
    chk("fail1", fail1, m_fail);
    chk("err0", err0, (m_mis > 7) ? 7 : m_mis);
    chk("err1", err1, (m_mis > 1) ? 1 : m_mis);
  end

  task automatic sweep(input int dw, input logic [3:0] tr, input int m, input bit repulse,
                       output int bc, output logic ps, output int e0, output int e1,
                       output logic [3:0] fv);
    bit got;
    @(negedge clk);
    gm = m; dwell = 8'(dw); truth = tr; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0; bc = 0; got = 0; ps = 1'bx; e0 = -1; e1 = -1; fv = 4'hx;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (busy0) begin
        bc++;
        start = (repulse && bc == 2);
      end
      if (done0) begin
        got = 1; ps = pass0; e0 = int'(err0); e1 = int'(err1); fv = fail0;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("sweep_done_seen", got, 1);
  endtask

  initial begin
    int bc, e0, e1;
    logic ps;
    logic [3:0] fv;
    bit seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dwell = '0; truth = '0; gm = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_ab", {a0, b0}, 0);
    chk("rst_err", err0, 0);
    rst_n = 1'b1;

    sweep(10, 4'b1110, 0, 0, bc, ps, e0, e1, fv);
    chk("or_busy_cycles", bc, 40);
    chk("or_pass", ps, 1);
    chk("or_err", e0, 0);
    chk("or_fail", fv, 4'b0000);

    sweep(10, 4'b1000, 0, 0, bc, ps, e0, e1, fv);
    chk("and_tbl_busy_cycles", bc, 40);
    chk("and_tbl_fail", fv, 4'b0110);
    chk("and_tbl_err", e0, 2);
    chk("and_tbl_pass", ps, 0);

    sweep(0, 4'b1110, 0, 1, bc, ps, e0, e1, fv);
    chk("dwell0_busy_cycles", bc, 4);
    chk("dwell0_pass", ps, 1);

    sweep(3, 4'b1111, 2, 1, bc, ps, e0, e1, fv);
    chk("sat_busy_cycles", bc, 12);
    chk("sat_err_w1", e1, 1);
    chk("sat_err_w3", e0, 4);
    chk("sat_fail", fv, 4'b1111);
    chk("sat_pass", ps, 0);

    // Abort during vector 01.
    @(negedge clk);
    gm = 0; dwell = 8'd5; truth = 4'b1110; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if ({a0, b0} == 2'b01) seen = 1;
      else @(negedge clk);
    end
    chk("abort_reached_v01", seen, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_ab", {a0, b0}, 0);
    chk("abort_pass", pass0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done0, 0);
      @(negedge clk);
    end
    sweep(5, 4'b1110, 0, 0, bc, ps, e0, e1, fv);
    chk("post_abort_busy_cycles", bc, 20);
    chk("post_abort_pass", ps, 1);

    // Asynchronous reset mid-sweep, with a mismatch already recorded.
    @(negedge clk);
    gm = 0; dwell = 8'd3; truth = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_err", err0, 1);
    chk("pre_rst_busy", busy0, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_ab", {a0, b0}, 0);
    chk("arst_err", err0, 0);
    chk("arst_fail", fail0, 0);
    chk("arst_done", done0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(3, 4'b1110, 0, 1, bc, ps, e0, e1, fv);
    chk("repulse_busy_cycles", bc, 12);
    chk("repulse_pass", ps, 1);

    // Randomized traffic; gate model only changes while no sweep is active.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      abort = ($urandom % 40) == 0;
      dwell = 8'($urandom_range(0, 6));
      truth = 4'($urandom);
      if (!m_run && !m_fin && ($urandom % 4) == 0) gm = int'($urandom % 4);
    end
    start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
